// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared definitions for the button debouncer:
//   - deb_state_e   : per-channel qualification FSM states
//   - deb_cnt_width : width of the stable-sample counter for a given cycle count
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_QUAL_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_QUAL_LOW  = 2'd3
  } deb_state_e;

  // Counter must hold the value DEBOUNCE_CYCLES itself; never narrower than 1 bit.
  function automatic int deb_cnt_width(input int cycles);
    int w;
    w = (cycles < 1) ? 1 : $clog2(cycles + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   One channel of the debouncer: SYNC_STAGES-flop synchroniser, four-state
//   qualification FSM and a saturating stable-sample counter.
// Ports
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   raw_in     in   asynchronous pin (active high)
//   level_out  out  debounced level
//   rise_pulse out  1-cycle pulse on accepted 0->1
//   fall_pulse out  1-cycle pulse on accepted 1->0
//   busy       out  a candidate change is being qualified
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int              CW      = deb_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  deb_state_e    r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic          r_rise, r_fall, w_rise_next, w_fall_next;

  // Synchroniser: shift towards the MSB, the MSB is the usable sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Saturating increment so the counter can never wrap back to an early value.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
    end
  end

  // The counter holds the number of consecutive differing samples seen so far.
  // A change is accepted on the edge that takes in the DEBOUNCE_CYCLES-th such
  // sample, so with a single required sample the first differing sample in a
  // stable state already completes the qualification.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rise_next  = 1'b0;
    w_fall_next  = 1'b0;
    case (r_state)
      ST_LOW: begin
        w_cnt_next = '0;
        if (w_sync) begin
          if (CNT_ONE >= CNT_MAX) begin
            w_state_next = ST_HIGH;
            w_rise_next  = 1'b1;
          end else begin
            w_state_next = ST_QUAL_HIGH;
            w_cnt_next   = CNT_ONE;
          end
        end
      end
      ST_QUAL_HIGH: begin
        if (!w_sync) begin
          w_state_next = ST_LOW;
          w_cnt_next   = '0;
        end else if (w_cnt_inc >= CNT_MAX) begin
          w_state_next = ST_HIGH;
          w_cnt_next   = '0;
          w_rise_next  = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      ST_HIGH: begin
        w_cnt_next = '0;
        if (!w_sync) begin
          if (CNT_ONE >= CNT_MAX) begin
            w_state_next = ST_LOW;
            w_fall_next  = 1'b1;
          end else begin
            w_state_next = ST_QUAL_LOW;
            w_cnt_next   = CNT_ONE;
          end
        end
      end
      ST_QUAL_LOW: begin
        if (w_sync) begin
          w_state_next = ST_HIGH;
          w_cnt_next   = '0;
        end else if (w_cnt_inc >= CNT_MAX) begin
          w_state_next = ST_LOW;
          w_cnt_next   = '0;
          w_fall_next  = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = ST_LOW;
        w_cnt_next   = '0;
      end
    endcase
  end

  // The accepted level is implied by the state: high while high or while
  // qualifying a fall.
  assign level_out  = (r_state == ST_HIGH) || (r_state == ST_QUAL_LOW);
  assign busy       = (r_state == ST_QUAL_HIGH) || (r_state == ST_QUAL_LOW);
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

endmodule

// File: rtl/button_debounce.sv
// button_debounce
//   Multi-channel synchroniser/debouncer for board buttons and switches.
//   Each channel is an independent debounce_channel instance.
// Ports
//   clk        in   clock, all logic in this domain
//   reset_n    in   asynchronous active-low reset
//   raw_in     in   NUM_INPUTS asynchronous pins, active high
//   level_out  out  NUM_INPUTS debounced levels
//   rise_pulse out  NUM_INPUTS 1-cycle pulses on accepted 0->1
//   fall_pulse out  NUM_INPUTS 1-cycle pulses on accepted 1->0
//   busy       out  NUM_INPUTS channel qualifying a candidate change
module button_debounce
  import debounce_pkg::*;
#(
  parameter int NUM_INPUTS      = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_INPUTS-1:0] raw_in,
  output logic [NUM_INPUTS-1:0] level_out,
  output logic [NUM_INPUTS-1:0] rise_pulse,
  output logic [NUM_INPUTS-1:0] fall_pulse,
  output logic [NUM_INPUTS-1:0] busy
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "button_debounce: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $fatal(1, "button_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw_in     (raw_in[gi]),
      .level_out  (level_out[gi]),
      .rise_pulse (rise_pulse[gi]),
      .fall_pulse (fall_pulse[gi]),
      .busy       (busy[gi])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce
//   Directed bench for button_debounce with NUM_INPUTS=2, SYNC_STAGES=2,
//   DEBOUNCE_CYCLES=8. Inputs are driven 1 time unit after a rising edge, outputs
//   are sampled 1 time unit after a rising edge. cyc counts rising edges, so an
//   input driven at cyc=t produces its accepted change at cyc=t+LAT.
module tb_button_debounce;

  localparam int N   = 2;
  localparam int S   = 2;
  localparam int D   = 8;
  localparam int LAT = S + D;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] raw_in;
  logic [N-1:0] level_out;
  logic [N-1:0] rise_pulse;
  logic [N-1:0] fall_pulse;
  logic [N-1:0] busy;

  button_debounce #(
    .NUM_INPUTS      (N),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .raw_in     (raw_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int rise_cnt [N];
  int rise_at  [N];
  int fall_cnt [N];
  int fall_at  [N];
  int overlap      = 0;
  int fall_both_at = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (cyc=%0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cyc=%0d)", tag, got, cyc);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < N; i++) begin
      rise_cnt[i] = 0;
      rise_at[i]  = -1;
      fall_cnt[i] = 0;
      fall_at[i]  = -1;
    end
    fall_both_at = -1;
  endtask

  // One clock edge, then record pulses seen after it.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (rise_pulse[i] === 1'b1) begin
        rise_cnt[i]++;
        rise_at[i] = cyc;
      end
      if (fall_pulse[i] === 1'b1) begin
        fall_cnt[i]++;
        fall_at[i] = cyc;
      end
    end
    if ((rise_pulse & fall_pulse) != '0) overlap++;
    if (fall_pulse == 2'b11) fall_both_at = cyc;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int t;
  int t2;

  initial begin
    clear_mon();

    // 1. Reset with both inputs held high.
    reset_n = 1'b0;
    raw_in  = 2'b11;
    #1;
    check("rst_async_outputs", {24'd0, level_out, rise_pulse, fall_pulse, busy}, 32'd0);
    run(3);
    check("rst_level", level_out, 2'b00);
    check("rst_pulses", {rise_pulse, fall_pulse}, 4'b0000);
    check("rst_busy", busy, 2'b00);
    reset_n = 1'b1;
    t = cyc;
    clear_mon();
    run(14);
    check("t1_rise0_at", rise_at[0], t + LAT);
    check("t1_rise1_at", rise_at[1], t + LAT);
    check("t1_rise0_cnt", rise_cnt[0], 1);
    check("t1_rise1_cnt", rise_cnt[1], 1);
    check("t1_level", level_out, 2'b11);

    raw_in = 2'b00;
    run(14);
    check("t1_back_low", level_out, 2'b00);

    // 2. Clean press and release on channel 0.
    clear_mon();
    t = cyc;
    raw_in[0] = 1'b1;
    run(30);
    check("t2_rise_at", rise_at[0], t + LAT);
    check("t2_rise_cnt", rise_cnt[0], 1);
    check("t2_level", level_out[0], 1'b1);
    t2 = cyc;
    raw_in[0] = 1'b0;
    run(15);
    check("t2_fall_at", fall_at[0], t2 + LAT);
    check("t2_fall_cnt", fall_cnt[0], 1);
    check("t2_level_low", level_out[0], 1'b0);

    // 3. Bounce on channel 0: 1x5, 0x2, 1x3, 0x1, then 1 held.
    clear_mon();
    t = cyc;
    raw_in[0] = 1'b1;
    run(5);
    check("t3_busy_a", busy[0], 1'b1);
    raw_in[0] = 1'b0;
    run(2);
    raw_in[0] = 1'b1;
    run(3);
    check("t3_busy_b", busy[0], 1'b1);
    raw_in[0] = 1'b0;
    run(1);
    raw_in[0] = 1'b1;
    t2 = cyc;
    run(15);
    check("t3_rise_cnt", rise_cnt[0], 1);
    check("t3_rise_at", rise_at[0], t2 + LAT);
    check("t3_level", level_out[0], 1'b1);
    raw_in[0] = 1'b0;
    run(15);
    check("t3_level_low", level_out[0], 1'b0);

    // 4. Seven-cycle glitch on channel 1: never accepted.
    clear_mon();
    t = cyc;
    raw_in[1] = 1'b1;
    run(7);
    raw_in[1] = 1'b0;
    run(1);
    check("t4_busy_held", busy[1], 1'b1);
    run(2);
    check("t4_busy_dropped", busy[1], 1'b0);
    run(10);
    check("t4_rise_cnt", rise_cnt[1], 0);
    check("t4_level", level_out[1], 1'b0);

    // 5. Reset while channel 0 has counted 5 samples.
    clear_mon();
    t = cyc;
    raw_in[0] = 1'b1;
    run(7);
    check("t5_busy_before", busy[0], 1'b1);
    reset_n = 1'b0;
    raw_in  = 2'b00;
    #1;
    check("t5_outputs_in_reset", {24'd0, level_out, rise_pulse, fall_pulse, busy}, 32'd0);
    run(3);
    reset_n = 1'b1;
    run(20);
    check("t5_rise_cnt", rise_cnt[0], 0);
    check("t5_level", level_out, 2'b00);
    check("t5_busy", busy, 2'b00);

    // 6. Independent channels, then a simultaneous release.
    clear_mon();
    t = cyc;
    raw_in[0] = 1'b1;
    run(3);
    raw_in[1] = 1'b1;
    run(15);
    check("t6_rise0_at", rise_at[0], t + LAT);
    check("t6_rise1_at", rise_at[1], t + 3 + LAT);
    check("t6_level", level_out, 2'b11);
    t2 = cyc;
    raw_in = 2'b00;
    run(15);
    check("t6_fall_both_at", fall_both_at, t2 + LAT);
    check("t6_fall0_cnt", fall_cnt[0], 1);
    check("t6_fall1_cnt", fall_cnt[1], 1);

    check("no_rise_fall_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
